vc_allocator: RTL and testbench

VC_ALLOCATOR -- requirements
Module: vc_allocator

---
 rtl/vc_allocator_if.sv | 11 +
 rtl/vc_allocator.sv | 101 ++++++++++
 tb/tb_vc_allocator.sv | 134 +++++++++++++
 3 files changed

// File: rtl/vc_allocator_if.sv
// vc_allocator_if: request/release inputs and grant/error outputs of the VC allocator
interface vc_allocator_if #(parameter int PORT_NUM = 5, parameter int VC_NUM = 2, parameter int VC_SIZE = 1);
  logic [PORT_NUM*VC_NUM-1:0]         vc_req_i;
  logic [PORT_NUM*VC_NUM*3-1:0]       out_port_i;
  logic [PORT_NUM*VC_NUM-1:0]         vc_release_i;
  logic [PORT_NUM*VC_NUM*VC_SIZE-1:0] vc_new_o;
  logic [PORT_NUM*VC_NUM-1:0]         vc_val_o;
  logic                               err_o;
  modport master (output vc_req_i, out_port_i, vc_release_i, input vc_new_o, vc_val_o, err_o);
  modport slave  (input vc_req_i, out_port_i, vc_release_i, output vc_new_o, vc_val_o, err_o);
endinterface

// File: rtl/vc_allocator.sv
// vc_allocator: per-output-port downstream VC allocator; VC_ALLOCATOR_RR_ARB_EN selects round-robin, else fixed priority
module vc_allocator #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 2,
  parameter int VC_SIZE  = 1
) (
  input logic clk,
  input logic rst,
  vc_allocator_if.slave bus
);
  localparam int N = PORT_NUM * VC_NUM;
  localparam int PW = $clog2(N);
  localparam logic [2:0] PN = 3'(PORT_NUM);
  logic [PORT_NUM-1:0][VC_NUM-1:0] free_q, free_d;
  logic [N-1:0] val_q, val_d, elig;
  logic [N*VC_SIZE-1:0] new_q, new_d;
  logic err_q, err_d;
`ifdef VC_ALLOCATOR_RR_ARB_EN
  logic [PORT_NUM-1:0][PW-1:0] rr_q, rr_d;
`endif
  always_comb begin
    int win, vsel, idx;
    logic found, vfound;
    free_d = free_q;
    val_d = '0;
    new_d = new_q;
    err_d = 1'b0;
    elig = '0;
    win = 0;
    vsel = 0;
    idx = 0;
    found = 1'b0;
    vfound = 1'b0;
`ifdef VC_ALLOCATOR_RR_ARB_EN
    rr_d = rr_q;
`endif
    for (int i = 0; i < N; i++) begin
      elig[i] = bus.vc_req_i[i] && !val_q[i] && (bus.out_port_i[i*3 +: 3] < PN);
      if (bus.vc_req_i[i] && !val_q[i] && (bus.out_port_i[i*3 +: 3] >= PN)) err_d = 1'b1;
    end
    // releases only touch allocated VCs and grants only free ones, so the two never collide
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++)
        if (bus.vc_release_i[p*VC_NUM+v]) begin
          if (free_q[p][v]) err_d = 1'b1;
          else free_d[p][v] = 1'b1;
        end
    for (int p = 0; p < PORT_NUM; p++) begin
      found = 1'b0;
      win = 0;
      for (int k = 0; k < N; k++) begin
`ifdef VC_ALLOCATOR_RR_ARB_EN
        idx = (int'(rr_q[p]) + k) % N;
`else
        idx = k;
`endif
        if (!found && elig[idx] && bus.out_port_i[idx*3 +: 3] == 3'(p)) begin
          found = 1'b1;
          win = idx;
        end
      end
      vfound = 1'b0;
      vsel = 0;
      for (int v = VC_NUM - 1; v >= 0; v--)
        if (free_q[p][v]) begin
          vfound = 1'b1;
          vsel = v;
        end
      if (found && vfound) begin
        val_d[win] = 1'b1;
        new_d[win*VC_SIZE +: VC_SIZE] = VC_SIZE'(vsel);
        free_d[p][vsel] = 1'b0;
`ifdef VC_ALLOCATOR_RR_ARB_EN
        rr_d[p] = PW'((win + 1) % N);
`endif
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_q <= '1;
      val_q <= '0;
      new_q <= '0;
      err_q <= 1'b0;
`ifdef VC_ALLOCATOR_RR_ARB_EN
      rr_q <= '0;
`endif
    end else begin
      free_q <= free_d;
      val_q <= val_d;
      new_q <= new_d;
      err_q <= err_d;
`ifdef VC_ALLOCATOR_RR_ARB_EN
      rr_q <= rr_d;
`endif
    end
  end
  assign bus.vc_val_o = val_q;
  assign bus.vc_new_o = new_q;
  assign bus.err_o = err_q;
endmodule

// File: tb/tb_vc_allocator.sv
// tb_vc_allocator: directed scoreboard bench; expected grant/error events are queued with their due cycle
module tb_vc_allocator;
  localparam int N = 10;
  typedef struct {
    int         cyc;
    logic [N-1:0] val;
    logic [N-1:0] newv;
    logic       err;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  vc_allocator_if #(.PORT_NUM(5), .VC_NUM(2), .VC_SIZE(1)) bus();
  vc_allocator #(.PORT_NUM(5), .VC_NUM(2), .VC_SIZE(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.vc_val_o != '0 || bus.err_o)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d val=%b new=%b err=%b", cyc, bus.vc_val_o, bus.vc_new_o, bus.err_o);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.val != bus.vc_val_o || e.newv != (bus.vc_new_o & bus.vc_val_o) || e.err != bus.err_o) begin
          errors++;
          $display("FAIL grant got cyc=%0d val=%b new=%b err=%b required cyc=%0d val=%b new=%b err=%b",
                   cyc, bus.vc_val_o, bus.vc_new_o & bus.vc_val_o, bus.err_o, e.cyc, e.val, e.newv, e.err);
        end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", nm, got, req);
    end
  endtask
  task automatic ex(input logic [N-1:0] v, input logic [N-1:0] n, input logic e);
    q.push_back('{cyc + 1, v, n, e});
  endtask
  task automatic rq(input int i, input int p);
    bus.vc_req_i[i] = 1'b1;
    bus.out_port_i[i*3 +: 3] = 3'(p);
  endtask
  task automatic reset_outputs_zero(input string nm);
    chk({nm, "_val"}, 32'(bus.vc_val_o), 0);
    chk({nm, "_new"}, 32'(bus.vc_new_o), 0);
    chk({nm, "_err"}, 32'(bus.err_o), 0);
  endtask
  task automatic do_reset;
    bus.vc_req_i = '0;
    bus.out_port_i = '0;
    bus.vc_release_i = '0;
    rst = 1'b1;
    tick;
    tick;
    reset_outputs_zero("reset");
    rst = 1'b0;
  endtask
  initial begin
    bus.vc_req_i = '0;
    bus.out_port_i = '0;
    bus.vc_release_i = '0;
    // single grant, one-cycle pulse, then the second VC of port 2, then exhaustion
    do_reset;
    rq(0, 2); ex(10'b1, 10'b0, 1'b0); tick;
    tick;
    ex(10'b1, 10'b1, 1'b0); tick;
    tick; tick; tick;
    bus.vc_req_i = '0; tick; tick;
    // three requesters on port 4: two get VCs, the third waits for a release
    do_reset;
    rq(1, 4); rq(3, 4); rq(5, 4); ex(10'b10, 10'b0, 1'b0); tick;
    bus.vc_req_i[1] = 1'b0; ex(10'b1000, 10'b1000, 1'b0); tick;
    bus.vc_req_i[3] = 1'b0; tick;
    bus.vc_release_i[8] = 1'b1; tick;
    bus.vc_release_i = '0; ex(10'b100000, 10'b0, 1'b0); tick;
    tick;
    bus.vc_req_i = '0; tick; tick;
    // fairness on port 1 with one VC held by input VC 9
    do_reset;
    rq(9, 1); ex(10'b1000000000, 10'b0, 1'b0); tick;
    bus.vc_req_i[9] = 1'b0; tick;
    rq(0, 1); rq(2, 1);
    for (int k = 0; k < 4; k++) begin
`ifdef VC_ALLOCATOR_RR_ARB_EN
      if (k % 2 == 0) ex(10'b1, 10'b1, 1'b0); else ex(10'b100, 10'b100, 1'b0);
`else
      ex(10'b1, 10'b1, 1'b0);
`endif
      tick;
      bus.vc_release_i[3] = 1'b1; tick;
      bus.vc_release_i = '0;
    end
    bus.vc_req_i = '0; tick; tick;
    // independent ports grant in the same cycle
    do_reset;
    rq(4, 1); rq(6, 3); ex(10'b1010000, 10'b0, 1'b0); tick;
    bus.vc_req_i = '0; tick; tick;
    // bad port, release of a free VC, and free state left intact
    do_reset;
    rq(3, 7); ex(10'b0, 10'b0, 1'b1); tick;
    bus.vc_req_i[3] = 1'b0; rq(0, 0); ex(10'b1, 10'b0, 1'b0); tick;
    bus.vc_req_i[0] = 1'b0; bus.vc_release_i[1] = 1'b1; ex(10'b0, 10'b0, 1'b1); tick;
    bus.vc_release_i = '0; rq(1, 0); ex(10'b10, 10'b10, 1'b0); tick;
    bus.vc_req_i[1] = 1'b0; bus.vc_release_i[0] = 1'b1; tick;
    bus.vc_release_i = '0; rq(2, 0); ex(10'b100, 10'b0, 1'b0); tick;
    bus.vc_req_i = '0; tick; tick;
    // reset while port 0 is fully allocated and a request is pending
    do_reset;
    rq(0, 0); rq(1, 0); ex(10'b1, 10'b0, 1'b0); tick;
    bus.vc_req_i[0] = 1'b0; ex(10'b10, 10'b10, 1'b0); tick;
    bus.vc_req_i[1] = 1'b0; rq(2, 0); tick;
    rst = 1'b1; #1;
    reset_outputs_zero("midrst");
    bus.vc_req_i = '0; tick;
    rst = 1'b0; rq(4, 0); rq(5, 0); ex(10'b10000, 10'b0, 1'b0); tick;
    bus.vc_req_i[4] = 1'b0; ex(10'b100000, 10'b100000, 1'b0); tick;
    bus.vc_req_i = '0; tick; tick; tick;
    chk("queue_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
